// File: rtl/nfa_ctrl_pkg.sv
// Shared types for the NFA branch stream controller: FSM states, the
// per-packet result record and the default field widths.
package nfa_ctrl_pkg;

    localparam int DEF_MATCH_LAT = 1;
    localparam int DEF_LEN_W     = 16;
    localparam int DEF_CNT_W     = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN   = 3'd1,
        DRAIN  = 3'd2,
        REPORT = 3'd3,
        FLUSH  = 3'd4
    } ctrl_state_e;

    // Result record as seen by the rule-result aggregator at default widths.
    typedef struct packed {
        logic                 hit;
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_LEN_W-1:0] first_pos;
        logic [DEF_LEN_W-1:0] len;
        logic                 gap;
        logic                 ovf;
    } nfa_result_t;

endpackage

// File: rtl/nfa_match_align.sv
// Delay line that re-times each presented byte's {fired, pos_ok, idx} by the
// branch's match latency, so a returning match can be attributed to the byte
// that completed it. Bubbles travel through with fired=0 and are ignored.
module nfa_match_align #(
    parameter int MATCH_LAT = 1,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             fired,
    input  logic             pos_ok,
    input  logic [LEN_W-1:0] idx,
    input  logic             match,
    output logic             hit,
    output logic             hit_pos_ok,
    output logic [LEN_W-1:0] hit_idx
);

    logic [MATCH_LAT-1:0]            fired_sr;
    logic [MATCH_LAT-1:0]            ok_sr;
    logic [MATCH_LAT-1:0][LEN_W-1:0] idx_sr;

    // Shift the byte tags one stage per cycle, including bubble cycles.
    // NOTE: this is a short tag pipeline, not a storage array, so it is reset
    // to keep a stale fired=1 from attributing a match after reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            fired_sr <= '0;
            ok_sr    <= '0;
            idx_sr   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous cycle's value regardless of statement order.
            fired_sr[0] <= fired;
            ok_sr[0]    <= pos_ok;
            idx_sr[0]   <= idx;
            for (int i = 1; i < MATCH_LAT; i++) begin
                fired_sr[i] <= fired_sr[i-1];
                ok_sr[i]    <= ok_sr[i-1];
                idx_sr[i]   <= idx_sr[i-1];
            end
        end
    end

    assign hit        = match & fired_sr[MATCH_LAT-1];
    assign hit_pos_ok = ok_sr[MATCH_LAT-1];
    assign hit_idx    = idx_sr[MATCH_LAT-1];

endmodule

// File: rtl/nfa_stream_ctrl.sv
// Sequences one chained-opchar NFA branch over a framed byte stream and
// produces one result record per packet (hit, count, first position, length,
// bubble and overflow flags). Reset is synchronous and active-high on reset_n.
module nfa_stream_ctrl
    import nfa_ctrl_pkg::*;
#(
    parameter int MATCH_LAT = DEF_MATCH_LAT,
    parameter int ANCHORED  = 0,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             nfa_en,
    output logic [7:0]       nfa_payload,
    input  logic             nfa_match,
    output logic             nfa_flush,
    output logic             r_valid,
    input  logic             r_ready,
    output logic             r_hit,
    output logic [CNT_W-1:0] r_count,
    output logic [LEN_W-1:0] r_first_pos,
    output logic [LEN_W-1:0] r_len,
    output logic             r_gap,
    output logic             r_ovf
);

    localparam int                DRAIN_W    = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(MATCH_LAT - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX    = {LEN_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    ctrl_state_e        state, next_state;
    logic               ready_q;
    logic [DRAIN_W-1:0] drain_q;
    logic [LEN_W-1:0]   len_q, first_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               hit_q, gap_q, ovf_q;

    logic               fire;
    logic [LEN_W-1:0]   idx;
    logic               pos_ok;
    logic               al_hit, al_pos_ok;
    logic [LEN_W-1:0]   al_idx;

    assign fire        = s_valid & ready_q;
    assign s_ready     = ready_q;
    // The byte index of the presented byte equals the bytes accepted so far.
    assign idx         = (state == SCAN) ? len_q : '0;
    // Once the length has saturated, later byte indices are no longer exact.
    assign pos_ok      = (state == IDLE) || !ovf_q;
    assign nfa_payload = s_data;
    assign nfa_en      = fire & ((ANCHORED == 0) || (idx == '0));

    nfa_match_align #(
        .MATCH_LAT (MATCH_LAT),
        .LEN_W     (LEN_W)
    ) u_align (
        .clk        (clk),
        .reset_n    (reset_n),
        .fired      (fire),
        .pos_ok     (pos_ok),
        .idx        (idx),
        .match      (nfa_match),
        .hit        (al_hit),
        .hit_pos_ok (al_pos_ok),
        .hit_idx    (al_idx)
    );

    // Next-state and state-decoded outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        next_state = state;
        r_valid    = 1'b0;
        nfa_flush  = 1'b0;
        unique case (state)
            IDLE:    if (fire) next_state = s_last ? DRAIN : SCAN;
            SCAN:    if (fire && s_last) next_state = DRAIN;
            DRAIN:   if (drain_q == DRAIN_LAST) next_state = REPORT;
            REPORT: begin
                r_valid = 1'b1;
                if (r_ready) next_state = FLUSH;
            end
            FLUSH: begin
                nfa_flush  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register; s_ready is registered from the next state so r_ready
    // never reaches s_ready combinationally.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state   <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == IDLE) || (next_state == SCAN);
        end
    end

    // Count the cycles spent waiting for the last byte's match to return.
    always_ff @(posedge clk) begin
        if (reset_n || state != DRAIN) drain_q <= '0;
        else                           drain_q <= drain_q + 1'b1;
    end

    // Per-packet accumulators: length, flags, match count and first position.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            len_q   <= '0;
            ovf_q   <= 1'b0;
            gap_q   <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            first_q <= '0;
        end else begin
            if (state == IDLE && fire) begin
                len_q   <= LEN_W'(1);
                ovf_q   <= 1'b0;
                gap_q   <= 1'b0;
                hit_q   <= 1'b0;
                cnt_q   <= '0;
                first_q <= '0;
            end else if (state == SCAN) begin
                if (!s_valid) gap_q <= 1'b1;
                if (fire) begin
                    if (len_q == LEN_MAX) ovf_q <= 1'b1;
                    else                  len_q <= len_q + LEN_W'(1);
                end
            end
            if ((state == SCAN || state == DRAIN) && al_hit) begin
                if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
                hit_q <= 1'b1;
                if (!hit_q && al_pos_ok) first_q <= al_idx;
            end
        end
    end

    assign r_hit       = hit_q;
    assign r_count     = cnt_q;
    assign r_first_pos = first_q;
    assign r_len       = len_q;
    assign r_gap       = gap_q;
    assign r_ovf       = ovf_q;

endmodule

// File: tb/tb_nfa_stream_ctrl.sv
// Bench for nfa_stream_ctrl: three configurations (unanchored, anchored,
// narrow LEN_W=4/CNT_W=2) run in lock step on the same stream, each driving
// its own "abc" chained-opchar branch stub. Results are compared with a
// packet-level model computed from the accepted bytes and their cycle stamps.
module tb_nfa_stream_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s_valid, s_last, r_ready;
    logic [7:0] s_data;

    logic       s_ready [3];
    logic       nfa_en [3];
    logic [7:0] nfa_payload [3];
    logic       nfa_flush [3];
    logic       r_valid [3];
    logic       r_hit [3];
    logic       r_gap [3];
    logic       r_ovf [3];
    logic [2:0] e1, e2, m;

    logic [7:0]  r_count0, r_count1;
    logic [1:0]  r_count2;
    logic [15:0] r_first0, r_first1, r_len0, r_len1;
    logic [3:0]  r_first2, r_len2;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic [7:0] pkt_q[$];
    int         bub_q[$];
    int         stamp_q[$];

    typedef struct {
        int hit;
        int count;
        int first_pos;
        int len;
        int gap;
        int ovf;
    } exp_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nfa_stream_ctrl u0 (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready[0]),
        .s_data(s_data), .s_last(s_last), .nfa_en(nfa_en[0]), .nfa_payload(nfa_payload[0]),
        .nfa_match(m[0]), .nfa_flush(nfa_flush[0]), .r_valid(r_valid[0]), .r_ready(r_ready),
        .r_hit(r_hit[0]), .r_count(r_count0), .r_first_pos(r_first0), .r_len(r_len0),
        .r_gap(r_gap[0]), .r_ovf(r_ovf[0])
    );

    nfa_stream_ctrl #(.ANCHORED(1)) u1 (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready[1]),
        .s_data(s_data), .s_last(s_last), .nfa_en(nfa_en[1]), .nfa_payload(nfa_payload[1]),
        .nfa_match(m[1]), .nfa_flush(nfa_flush[1]), .r_valid(r_valid[1]), .r_ready(r_ready),
        .r_hit(r_hit[1]), .r_count(r_count1), .r_first_pos(r_first1), .r_len(r_len1),
        .r_gap(r_gap[1]), .r_ovf(r_ovf[1])
    );

    nfa_stream_ctrl #(.LEN_W(4), .CNT_W(2)) u2 (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready[2]),
        .s_data(s_data), .s_last(s_last), .nfa_en(nfa_en[2]), .nfa_payload(nfa_payload[2]),
        .nfa_match(m[2]), .nfa_flush(nfa_flush[2]), .r_valid(r_valid[2]), .r_ready(r_ready),
        .r_hit(r_hit[2]), .r_count(r_count2), .r_first_pos(r_first2), .r_len(r_len2),
        .r_gap(r_gap[2]), .r_ovf(r_ovf[2])
    );

    // Branch stub per instance: registered 'a' -> 'b' -> 'c' opchar chain.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset_n || nfa_flush[i]) begin
                e1[i] <= 1'b0;
                e2[i] <= 1'b0;
                m[i]  <= 1'b0;
            end else begin
                e1[i] <= nfa_en[i] && nfa_payload[i] == 8'h61;
                e2[i] <= e1[i] && nfa_payload[i] == 8'h62;
                m[i]  <= e2[i] && nfa_payload[i] == 8'h63;
            end
        end
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic timeout_fail(string tag);
        total++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Packet-level reference: "abc" occurrences whose three bytes were
    // accepted on consecutive cycles, then saturation of count and length.
    function automatic exp_t model(int anchored, int len_w, int cnt_w);
        exp_t e;
        int   n       = 0;
        int   first   = -1;
        int   l       = pkt_q.size();
        int   len_max = (1 << len_w) - 1;
        int   cnt_max = (1 << cnt_w) - 1;
        for (int k = 2; k < l; k++) begin
            if (pkt_q[k-2] == 8'h61 && pkt_q[k-1] == 8'h62 && pkt_q[k] == 8'h63 &&
                stamp_q[k] == stamp_q[k-2] + 2 && (anchored == 0 || k == 2)) begin
                n++;
                if (first < 0) first = k;
            end
        end
        e.hit       = (n > 0) ? 1 : 0;
        e.count     = (n > cnt_max) ? cnt_max : n;
        e.first_pos = (n > 0 && first <= len_max) ? first : 0;
        e.len       = (l > len_max) ? len_max : l;
        e.ovf       = (l > len_max) ? 1 : 0;
        e.gap       = (l > 1 && stamp_q[l-1] - stamp_q[0] != l - 1) ? 1 : 0;
        return e;
    endfunction

    task automatic check_inst(string tag, exp_t e, logic hit, logic [31:0] cnt,
                              logic [31:0] fp, logic [31:0] len, logic gap, logic ovf);
        check({tag, ".hit"}, {31'd0, hit}, e.hit);
        check({tag, ".count"}, cnt, e.count);
        check({tag, ".first_pos"}, fp, e.first_pos);
        check({tag, ".len"}, len, e.len);
        check({tag, ".gap"}, {31'd0, gap}, e.gap);
        check({tag, ".ovf"}, {31'd0, ovf}, e.ovf);
    endtask

    task automatic check_result(string ph);
        check_inst({ph, ".u0"}, model(0, 16, 8), r_hit[0], {24'd0, r_count0},
                   {16'd0, r_first0}, {16'd0, r_len0}, r_gap[0], r_ovf[0]);
        check_inst({ph, ".u1"}, model(1, 16, 8), r_hit[1], {24'd0, r_count1},
                   {16'd0, r_first1}, {16'd0, r_len1}, r_gap[1], r_ovf[1]);
        check_inst({ph, ".u2"}, model(0, 4, 2), r_hit[2], {30'd0, r_count2},
                   {28'd0, r_first2}, {28'd0, r_len2}, r_gap[2], r_ovf[2]);
    endtask

    task automatic set_pkt(string s);
        pkt_q.delete();
        bub_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            pkt_q.push_back(s[i]);
            bub_q.push_back(0);
        end
    endtask

    // Drive one packet, collect its result with rdelay cycles of backpressure,
    // and check the flush pulse and the return to IDLE.
    task automatic run_packet(string ph, int rdelay);
        int l = pkt_q.size();
        int w;
        stamp_q.delete();
        for (int i = 0; i < l; i++) begin
            if (i > 0) begin
                repeat (bub_q[i]) begin
                    s_valid = 1'b0; s_data = 8'h63; s_last = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1; s_data = pkt_q[i]; s_last = (i == l - 1);
            w = 0;
            while (!(s_ready[0] && s_ready[1] && s_ready[2]) && w < 20) begin
                @(posedge clk); #1; w++;
            end
            if (w == 20) begin
                timeout_fail({ph, ".s_ready"});
                return;
            end
            #1;
            if (i < 3) begin
                check({ph, ".payload"}, {24'd0, nfa_payload[0]}, {24'd0, pkt_q[i]});
                check({ph, ".en_unanch"}, {31'd0, nfa_en[0]}, 1);
                check({ph, ".en_anch"}, {31'd0, nfa_en[1]}, (i == 0) ? 1 : 0);
            end
            @(posedge clk); #1;
            stamp_q.push_back(cyc);
        end
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'h63;
        check({ph, ".drain_ready"}, {31'd0, s_ready[0]}, 0);
        w = 0;
        while (!r_valid[0] && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (w == 20) begin
            timeout_fail({ph, ".r_valid"});
            return;
        end
        check({ph, ".latency"}, w, 1);
        check_result(ph);
        repeat (rdelay) begin
            r_ready = 1'b0;
            @(posedge clk); #1;
            check({ph, ".hold_valid"}, {31'd0, r_valid[0]}, 1);
            check({ph, ".hold_ready"}, {31'd0, s_ready[0]}, 0);
            check_result({ph, ".hold"});
        end
        r_ready = 1'b1;
        @(posedge clk); #1;
        r_ready = 1'b0;
        check({ph, ".flush"}, {31'd0, nfa_flush[0]}, 1);
        check({ph, ".flush_u2"}, {31'd0, nfa_flush[2]}, 1);
        check({ph, ".flush_valid"}, {31'd0, r_valid[0]}, 0);
        check({ph, ".flush_ready"}, {31'd0, s_ready[0]}, 0);
        @(posedge clk); #1;
        check({ph, ".idle_flush"}, {31'd0, nfa_flush[0]}, 0);
        check({ph, ".idle_ready"}, {31'd0, s_ready[0]}, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int l;
        reset_n = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h63; r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.s_ready", {31'd0, s_ready[0]}, 0);
        check("reset.r_valid", {31'd0, r_valid[0]}, 0);
        check("reset.flush", {31'd0, nfa_flush[0]}, 0);
        check("reset.count", {24'd0, r_count0}, 0);
        check("reset.len", {16'd0, r_len0}, 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("release.s_ready", {31'd0, s_ready[0]}, 1);

        set_pkt("abc");
        run_packet("single", 0);
        set_pkt("xabcabc");
        run_packet("repeat", 1);
        set_pkt("abc");
        bub_q[2] = 2;
        run_packet("bubble", 0);
        set_pkt("abc");
        run_packet("backpressure", 5);

        // Abandon a packet mid-SCAN with reset.
        s_valid = 1'b1; s_data = 8'h61; s_last = 1'b0;
        @(posedge clk); #1;
        s_data = 8'h62;
        @(posedge clk); #1;
        s_valid = 1'b0; s_data = 8'h63; reset_n = 1'b1;
        @(posedge clk); #1;
        check("midreset.s_ready", {31'd0, s_ready[0]}, 0);
        check("midreset.r_valid", {31'd0, r_valid[0]}, 0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midreset.release_ready", {31'd0, s_ready[0]}, 1);
        repeat (3) begin
            @(posedge clk); #1;
            check("midreset.no_result", {31'd0, r_valid[0]}, 0);
        end
        set_pkt("abc");
        run_packet("after_reset", 0);

        set_pkt("abcabcabcabcabcxxxxx");
        run_packet("saturate", 2);
        set_pkt("c");
        run_packet("one_byte", 0);

        for (int p = 0; p < 25; p++) begin
            l = $urandom_range(1, 24);
            pkt_q.delete();
            bub_q.delete();
            while (pkt_q.size() < l) begin
                if ($urandom_range(0, 2) == 0) begin
                    pkt_q.push_back(8'h61); pkt_q.push_back(8'h62); pkt_q.push_back(8'h63);
                end else begin
                    case ($urandom_range(0, 3))
                        0:       pkt_q.push_back(8'h61);
                        1:       pkt_q.push_back(8'h62);
                        2:       pkt_q.push_back(8'h63);
                        default: pkt_q.push_back(8'h78);
                    endcase
                end
            end
            while (pkt_q.size() > l) void'(pkt_q.pop_back());
            for (int i = 0; i < l; i++)
                bub_q.push_back(($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0);
            run_packet($sformatf("rand%0d", p), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
